// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared state type, pin constants and one-hot-low decode for key_scan_ctrl
package key_scan_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;
  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } onehot_t;
  function automatic onehot_t onehot_low(input logic [3:0] p);
    onehot_t r;
    r.vld = 1'b0;
    r.idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (p == ~(4'b0001 << i)) begin
        r.vld = 1'b1;
        r.idx = 2'(i);
      end
    return r;
  endfunction
endpackage

// File: rtl/key_row_sync.sv
// key_row_sync: 2-flop synchroniser for the asynchronous active-low keypad rows
module key_row_sync
  import key_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] row_s_o
);
  logic [3:0] s1_q, s2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= ROW_IDLE;
      s2_q <= ROW_IDLE;
    end else begin
      s1_q <= row_i;
      s2_q <= s1_q;
    end
  assign row_s_o = s2_q;
endmodule

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: sequenced, debounced 4x4 keypad scanner emitting one key_valid pulse per press.
// Define KEY_SCAN_REPEAT_EN to re-pulse key_valid every REPEAT_SLOTS held samples.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50_000,
  parameter int DEBOUNCE_CNT = 5,
  parameter int REPEAT_SLOTS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_down_o
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cand_q, cand_d, code_q, code_d, row_s;
  logic [CW-1:0] stab_q, stab_d, rel_q, rel_d;
  logic          valid_q, valid_d, down_q, down_d;
  logic          sample, match, rel_done, acc, rep_hit;
  onehot_t       oh;
  key_row_sync u_sync (.clk(clk), .rst(rst), .row_i(row_i), .row_s_o(row_s));
  assign sample   = slot_q == SLOT_LAST;
  assign slot_d   = sample ? '0 : slot_q + 1'b1;
  assign oh       = onehot_low(row_s);
  assign match    = row_s == cand_q;
  assign rel_done = row_s == ROW_IDLE && rel_q == DB_LAST;
  // a single debounce sample means the capture itself accepts the key
  assign acc = sample && ((state_q == SCAN && oh.vld && DB_LAST == '0) ||
                          (state_q == DEBOUNCE && match && stab_q == DB_LAST));
`ifdef KEY_SCAN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SLOTS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SLOTS - 1);
  logic [RW-1:0] rep_q, rep_d;
  assign rep_hit = sample && state_q == HELD && match && rep_q == REP_LAST;
  always_comb begin
    rep_d = rep_q;
    if (sample && state_q == HELD) rep_d = match && rep_q != REP_LAST ? rep_q + 1'b1 : '0;
    if (acc) rep_d = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rep_q <= '0;
    else rep_q <= rep_d;
`else
  logic unused_rep;
  assign unused_rep = ^REPEAT_SLOTS;
  assign rep_hit    = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    rel_d   = rel_q;
    code_d  = code_q;
    down_d  = down_q;
    valid_d = acc || rep_hit;
    if (sample)
      case (state_q)
        SCAN: begin
          state_d = oh.vld ? DEBOUNCE : SCAN;
          col_d   = oh.vld ? col_q : col_q + 1'b1;
          cand_d  = oh.vld ? row_s : cand_q;
          stab_d  = CW'(oh.vld);
        end
        DEBOUNCE: begin
          state_d = match ? DEBOUNCE : SCAN;
          col_d   = match ? col_q : col_q + 1'b1;
          stab_d  = match ? stab_q + 1'b1 : '0;
        end
        HELD: begin
          rel_d   = row_s == ROW_IDLE && !rel_done ? rel_q + 1'b1 : '0;
          state_d = rel_done ? SCAN : HELD;
          col_d   = rel_done ? '0 : col_q;
          down_d  = !rel_done;
        end
        default: state_d = SCAN;
      endcase
    if (acc) begin
      state_d = HELD;
      stab_d  = '0;
      rel_d   = '0;
      down_d  = 1'b1;
      code_d  = {oh.idx, col_q};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SCAN;
      slot_q  <= '0;
      col_q   <= '0;
      cand_q  <= ROW_IDLE;
      stab_q  <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      col_q   <= col_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  assign col_o       = ~(~COL_RESET << col_q);
  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_down_o  = down_q;
endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: directed keypad scenarios plus randomized presses against a sample-level model
module tb_key_scan_ctrl;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RS = 4;
`ifdef KEY_SCAN_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif
  logic clk, rst;
  logic [3:0] row_i, col_o, key_code_o, key;
  logic key_valid_o, key_down_o, pressed, force_hi, multi;
  int checks, errors, pulses;
  int m_mode, m_col, m_slot, m_stab, m_rel, m_rep, m_code, m_valid, m_down;
  logic [3:0] m_cand, h1, h2;
  logic [3:0] exp_idle [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  key_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_SLOTS(RS)) dut (
    .clk(clk), .rst(rst), .row_i(row_i), .col_o(col_o),
    .key_code_o(key_code_o), .key_valid_o(key_valid_o), .key_down_o(key_down_o)
  );
  assign row_i = force_hi ? 4'hF :
                 multi ? (col_o[0] ? 4'hF : 4'b1100) :
                 (pressed && !col_o[key[1:0]]) ? ~(4'b0001 << key[3:2]) : 4'hF;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: at each sample point apply the scan/debounce/hold rules to the delayed row value
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_col = 0; m_slot = 0; m_stab = 0; m_rel = 0; m_rep = 0;
      m_code = 0; m_valid = 0; m_down = 0; m_cand = 4'hF; h1 = 4'hF; h2 = 4'hF;
    end else begin
      logic [3:0] rs;
      int lows, ridx;
      rs = h2; h2 = h1; h1 = row_i;
      m_valid = 0;
      if (m_slot == SD - 1) begin
        m_slot = 0;
        lows = 0; ridx = 0;
        for (int i = 0; i < 4; i++) if (!rs[i]) begin lows++; ridx = i; end
        if (m_mode == 0) begin
          if (lows == 1) begin m_cand = rs; m_stab = 1; m_mode = 1; end
          else m_col = (m_col + 1) % 4;
        end else if (m_mode == 1) begin
          if (rs == m_cand) m_stab++;
          else begin m_mode = 0; m_col = (m_col + 1) % 4; end
        end else begin
          m_rel = (rs == 4'hF) ? m_rel + 1 : 0;
          if (REP_ON == 1) begin
            m_rep = (rs == m_cand) ? m_rep + 1 : 0;
            if (m_rep == RS) begin m_valid = 1; m_rep = 0; end
          end
          if (m_rel == DB) begin m_down = 0; m_mode = 0; m_col = 0; m_rel = 0; end
        end
        if (m_mode == 1 && m_stab == DB) begin
          m_valid = 1; m_down = 1; m_code = ridx * 4 + m_col; m_mode = 2; m_rel = 0; m_rep = 0;
        end
      end else m_slot++;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("col", int'(col_o), 15 ^ (1 << m_col));
    chk("key_valid", int'(key_valid_o), m_valid);
    chk("key_down", int'(key_down_o), m_down);
    chk("key_code", int'(key_code_o), m_code);
    if (key_valid_o) pulses++;
  end
  task automatic wait_pulse(input int budget, input int p0, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (pulses != p0) begin ok = 1; break; end
    end
  endtask
  task automatic wait_release(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (!key_down_o) begin n = c; break; end
    end
  endtask
  initial begin
    bit ok;
    int p0, p1, n, nb, hold;
    rst = 1; key = 0; pressed = 0; force_hi = 0; multi = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int s = 0; s < 8; s++) begin
      repeat (4) @(negedge clk);
      chk("idle_col_step", int'(col_o), int'(exp_idle[(s + 1) % 4]));
    end
    #1;
    chk("idle_no_pulse", pulses, 0);
    chk("idle_down", int'(key_down_o), 0);
    p0 = pulses; key = 4'd1; pressed = 1;
    wait_pulse(200, p0, ok);
    chk("k1_accept", int'(ok), 1);
    chk("k1_code", int'(key_code_o), 1);
    chk("k1_down", int'(key_down_o), 1);
    repeat (40) @(negedge clk);
    #1;
    chk("k1_pulses", pulses - p0, REP_ON ? 3 : 1);
    pressed = 0;
    wait_release(60, n);
    chk("k1_release_window", int'(n >= 10 && n <= 14), 1);
    chk("k1_col_restart", int'(col_o), 4'b1110);
    p0 = pulses; key = 4'd9; pressed = 1; ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_mode == 1) begin ok = 1; break; end
    end
    chk("k9_capture", int'(ok), 1);
    chk("k9_capture_col", int'(col_o), 4'b1101);
    force_hi = 1;
    repeat (4) @(negedge clk);
    force_hi = 0;
    #1;
    chk("k9_col_advance", int'(col_o), 4'b1011);
    chk("k9_no_pulse", pulses - p0, 0);
    wait_pulse(200, p0, ok);
    chk("k9_accept", int'(ok), 1);
    chk("k9_code", int'(key_code_o), 9);
    pressed = 0;
    wait_release(60, n);
    chk("k9_released", int'(n > 0), 1);
    p0 = pulses; multi = 1;
    repeat (64) @(negedge clk);
    #1;
    chk("ghost_no_pulse", pulses - p0, 0);
    chk("ghost_down", int'(key_down_o), 0);
    multi = 0;
    p0 = pulses; key = 4'd14; pressed = 1;
    wait_pulse(200, p0, ok);
    chk("k14_accept", int'(ok), 1);
    chk("k14_code", int'(key_code_o), 14);
    repeat (6) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("rst_col", int'(col_o), 4'b1110);
    chk("rst_down", int'(key_down_o), 0);
    chk("rst_code", int'(key_code_o), 0);
    chk("rst_valid", int'(key_valid_o), 0);
    @(negedge clk);
    rst = 0;
    p0 = pulses;
    wait_pulse(200, p0, ok);
    chk("k14_reaccept", int'(ok), 1);
    chk("k14_recode", int'(key_code_o), 14);
    repeat (10) @(negedge clk);
    #1;
    chk("k14_one_pulse", pulses - p0, 1);
    pressed = 0;
    wait_release(60, n);
    chk("k14_released", int'(n > 0), 1);
    p0 = pulses; key = 4'd2; pressed = 1;
    wait_pulse(200, p0, ok);
    chk("k2_accept", int'(ok), 1);
    p1 = pulses;
    repeat (76) @(negedge clk);
    #1;
    chk("k2_repeats", pulses - p1, REP_ON ? 4 : 0);
    chk("k2_code", int'(key_code_o), 2);
    pressed = 0;
    wait_release(60, n);
    chk("k2_released", int'(n > 0), 1);
    for (int it = 0; it < 12; it++) begin
      key = 4'($urandom_range(0, 15));
      p0 = pulses;
      nb = $urandom_range(0, 6);
      for (int b = 0; b < nb; b++) begin
        pressed = ~pressed;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      pressed = 1;
      wait_pulse(300, p0, ok);
      chk("rnd_accept", int'(ok), 1);
      hold = $urandom_range(0, 60);
      for (int c = 0; c < hold; c++) begin
        force_hi = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      force_hi = 0; pressed = 0;
      wait_release(100, n);
      chk("rnd_released", int'(n > 0), 1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
